pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives write-enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and it generates PCSrc. It handles three events: load-use hazards detected in ID, branch/jump redirects resolved in MEM, and multi-cycle data-memory accesses in MEM. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- MEM_WAIT_CYCLES, 2, extra stall cycles per data-memory access (0..15; 0 = single-cycle memory)
- CNT_W, 16, width of the performance counters

- Clk  in  1  clock; all state updates on posedge
- Rst_n  in  1  synchronous, active-low reset, sampled on posedge Clk
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID
- ID_UsesRt  in  1  the ID instruction reads Rt as a source
- EX_MemRead  in  1  the instruction in EX is a load
- EX_DestReg  in  5  destination register of the EX instruction
- MEM_Branch, MEM_Zero, MEM_NotZero  in  1 each  branch controls from EX/MEM
- MEM_Jump  in  2  00 none, 01 j/jal, 10 jr, 11 reserved (treated as none)
- MEM_MemRead, MEM_MemWrite  in  1 each  data-memory access in MEM
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  register update enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  out  1 each  load a bubble (all control fields 0)
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 jr register
- StallCount, FlushCount  out  CNT_W each  saturating event counters

## Operation
- Registered state: State {RUN, WAIT}, WaitCnt[3:0], StallCount, FlushCount. All other outputs are combinational from the inputs and the state.
- Events:
  - MemAccess = MEM_MemRead | MEM_MemWrite.
  - Taken = MEM_Branch & (MEM_NotZero ? ~MEM_Zero : MEM_Zero).
  - Redirect = Taken | MEM_Jump==01 | MEM_Jump==10.
  - LoadUse = EX_MemRead & EX_DestReg!=0 & (EX_DestReg==ID_Rs | (ID_UsesRt & EX_DestReg==ID_Rt)).
- MemStall:
  - In RUN: MemAccess & MEM_WAIT_CYCLES!=0.
  - In WAIT: WaitCnt!=0.
- Priority is MemStall > Redirect > LoadUse > normal.
- MemStall:
  - PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0.
  - MEM_WB_Write=1 with MEM_WB_Flush=1, so the MEM/WB register takes a bubble.
  - Redirect and LoadUse are ignored. PCSrc=00.
- Redirect:
  - All writes are 1. IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush are 1.
  - PCSrc: Taken→01, Jump 01→10, Jump 10→11. Taken has priority over Jump.
- LoadUse:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
  - All other writes are 1.
- Normal: all writes 1, all flushes 0, PCSrc=00.
- FSM:
  - RUN→WAIT when MemStall, loading WaitCnt=MEM_WAIT_CYCLES-1.
  - WAIT with WaitCnt!=0: decrement WaitCnt and stay in WAIT.
  - WAIT with WaitCnt==0: no stall this cycle, the access completes and advances; next state RUN.
  - Net effect: each access stalls exactly MEM_WAIT_CYCLES cycles.
- Counters:
  - StallCount increments on every cycle with MemStall or (LoadUse and not Redirect).
  - FlushCount increments on every Redirect cycle that is not stalled.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset:
  - State=RUN, WaitCnt=0, StallCount=0, FlushCount=0.
  - During reset, all combinational outputs are forced: writes 1, flushes 0, PCSrc=00.
- Reset asserted during WAIT aborts the wait. The first cycle after release is RUN, with no residual stall.
- Load-use costs 1 bubble. The same load reaches MEM the next cycle, where a memory stall may follow immediately.
- Redirect costs 3 squashed instructions. The correct-path fetch starts on the cycle after Redirect.
- Back-to-back memory accesses: the second access enters MEM on the cycle after WAIT ends, and RUN re-detects it without a gap cycle.
- MEM_WAIT_CYCLES=0: the WAIT state is never entered.

## Test plan
- Load-use: lw $t0 in EX (EX_MemRead=1, EX_DestReg=8), ID_Rs=8 → for exactly 1 cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount 0→1.
- Load-use excluded by register 0: EX_DestReg=0 with ID_Rs=0 → no stall. Separately, EX_DestReg=9, ID_Rt=9, ID_UsesRt=0 → no stall.
- Taken beq: MEM_Branch=1, MEM_Zero=1, MEM_NotZero=0 → PCSrc=01, IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush all 1 for 1 cycle; FlushCount=1. Repeat with bne (MEM_NotZero=1), Zero=1 → no redirect.
- Memory wait, MEM_WAIT_CYCLES=2: MEM_MemRead held → freeze for 2 cycles with MEM_WB_Flush=1, 3rd cycle releases; StallCount=2. A concurrent LoadUse is ignored during the freeze.
- Reset mid-wait with MEM_WAIT_CYCLES=3: Rst_n low in the 2nd WAIT cycle → next cycle State=RUN and counters 0; with MEM access inputs now 0, no stall.
- Saturation: preload StallCount near max (CNT_W=4, 15 stalls) → the 16th stall leaves StallCount=15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush sequencer for the five-stage MIPS pipeline.
// Arbitrates three hazard sources:
//   - memory stalls from multi-cycle data-memory accesses in MEM
//   - branch/jump redirects resolved in MEM
//   - load-use hazards detected in ID
// It produces the write enables and bubble flushes for the PC and each
// pipeline register, selects the next-PC source, and keeps saturating
// stall/flush event counters for performance debug.
//
// Parameters:
//   MEM_WAIT_CYCLES  extra stall cycles per data-memory access (0..15)
//   CNT_W            width of the performance counters
// Ports:
//   Clk, Rst_n                    clock, synchronous active-low reset
//   ID_Rs, ID_Rt, ID_UsesRt       source operands of the ID instruction
//   EX_MemRead, EX_DestReg        load in EX and its destination
//   MEM_Branch/Zero/NotZero       branch controls in MEM
//   MEM_Jump                      00 none, 01 j/jal, 10 jr, 11 none
//   MEM_MemRead, MEM_MemWrite     data-memory access in MEM
//   PCWrite .. MEM_WB_Write       pipeline register update enables
//   IF_ID_Flush .. MEM_WB_Flush   load a bubble into the register
//   PCSrc                         00 PC+4, 01 branch, 10 jump, 11 jr
//   StallCount, FlushCount        saturating event counters
module pipeline_ctrl #(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_DestReg,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  input  logic             MEM_NotZero,
  input  logic [1:0]       MEM_Jump,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Flush,
  output logic [1:0]       PCSrc,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // The RUN cycle that detects the access is itself the first stall cycle,
  // so WAIT only has to cover the remaining MEM_WAIT_CYCLES-1 cycles.
  localparam bit         HAS_WAIT  = (MEM_WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MEM_WAIT_CYCLES - 1) : 4'd0;

  logic [0:0] state;
  logic [3:0] waitCnt;

  logic memAccess;
  logic taken;
  logic redirect;
  logic loadUse;
  logic memStall;
  logic stallEvent;
  logic flushEvent;

  // Hazard detection. Register 0 never creates a load-use dependency, and
  // Rt only matters when the ID instruction actually reads it.
  always_comb begin
    memAccess = MEM_MemRead | MEM_MemWrite;
    taken     = MEM_Branch & (MEM_NotZero ? ~MEM_Zero : MEM_Zero);
    redirect  = taken | (MEM_Jump == 2'b01) | (MEM_Jump == 2'b10);
    loadUse   = EX_MemRead & (EX_DestReg != 5'd0) &
                ((EX_DestReg == ID_Rs) | (ID_UsesRt & (EX_DestReg == ID_Rt)));
    if (state == RUN) begin
      memStall = memAccess & HAS_WAIT;
    end else begin
      memStall = (waitCnt != 4'd0);
    end
    stallEvent = memStall | (loadUse & ~redirect);
    flushEvent = redirect & ~memStall;
  end

  // Control outputs, priority MemStall > Redirect > LoadUse > normal.
  // While in reset the pipeline is left free-running with no bubbles.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Flush = 1'b0;
    PCSrc        = 2'b00;
    if (Rst_n) begin
      if (memStall) begin
        // Freeze everything up to MEM; WB gets a bubble each stalled cycle.
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Flush = 1'b1;
      end else if (redirect) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
        if (taken) begin
          PCSrc = 2'b01;
        end else if (MEM_Jump == 2'b01) begin
          PCSrc = 2'b10;
        end else begin
          PCSrc = 2'b11;
        end
      end else if (loadUse) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  // Wait sequencer. When WAIT reaches zero the access completes that cycle
  // and RUN picks up any following access on the very next cycle.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= RUN;
      waitCnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state   <= WAIT;
            waitCnt <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state   <= RUN;
          waitCnt <= 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stallEvent && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (flushEvent && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Three instances share one input set:
//   dutA  MEM_WAIT_CYCLES=2, CNT_W=4  (main behaviour and saturation)
//   dutB  MEM_WAIT_CYCLES=3, CNT_W=16 (reset during a wait)
//   dutC  MEM_WAIT_CYCLES=0, CNT_W=16 (no wait state at all)
// Control outputs are packed as
//   {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
//    IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush}.
module tb_pipeline_ctrl;

  localparam logic [8:0] CTL_NORMAL   = 9'b11111_0000;
  localparam logic [8:0] CTL_LOADUSE  = 9'b00111_0100;
  localparam logic [8:0] CTL_REDIRECT = 9'b11111_1110;
  localparam logic [8:0] CTL_MEMSTALL = 9'b00001_0001;

  logic       Clk;
  logic       Rst_n;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic       EX_MemRead;
  logic [4:0] EX_DestReg;
  logic       MEM_Branch;
  logic       MEM_Zero;
  logic       MEM_NotZero;
  logic [1:0] MEM_Jump;
  logic       MEM_MemRead;
  logic       MEM_MemWrite;

  logic [8:0]  ctlA, ctlB, ctlC;
  logic [1:0]  pcSrcA, pcSrcB, pcSrcC;
  logic [3:0]  stallA, flushA;
  logic [15:0] stallB, flushB, stallC, flushC;

  int checkCount = 0;
  int errorCount = 0;

  pipeline_ctrl #(.MEM_WAIT_CYCLES(2), .CNT_W(4)) dutA (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_DestReg(EX_DestReg),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_NotZero(MEM_NotZero),
    .MEM_Jump(MEM_Jump), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PCWrite(ctlA[8]), .IF_ID_Write(ctlA[7]), .ID_EX_Write(ctlA[6]),
    .EX_MEM_Write(ctlA[5]), .MEM_WB_Write(ctlA[4]),
    .IF_ID_Flush(ctlA[3]), .ID_EX_Flush(ctlA[2]), .EX_MEM_Flush(ctlA[1]),
    .MEM_WB_Flush(ctlA[0]), .PCSrc(pcSrcA),
    .StallCount(stallA), .FlushCount(flushA)
  );

  pipeline_ctrl #(.MEM_WAIT_CYCLES(3), .CNT_W(16)) dutB (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_DestReg(EX_DestReg),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_NotZero(MEM_NotZero),
    .MEM_Jump(MEM_Jump), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PCWrite(ctlB[8]), .IF_ID_Write(ctlB[7]), .ID_EX_Write(ctlB[6]),
    .EX_MEM_Write(ctlB[5]), .MEM_WB_Write(ctlB[4]),
    .IF_ID_Flush(ctlB[3]), .ID_EX_Flush(ctlB[2]), .EX_MEM_Flush(ctlB[1]),
    .MEM_WB_Flush(ctlB[0]), .PCSrc(pcSrcB),
    .StallCount(stallB), .FlushCount(flushB)
  );

  pipeline_ctrl #(.MEM_WAIT_CYCLES(0), .CNT_W(16)) dutC (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_DestReg(EX_DestReg),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_NotZero(MEM_NotZero),
    .MEM_Jump(MEM_Jump), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PCWrite(ctlC[8]), .IF_ID_Write(ctlC[7]), .ID_EX_Write(ctlC[6]),
    .EX_MEM_Write(ctlC[5]), .MEM_WB_Write(ctlC[4]),
    .IF_ID_Flush(ctlC[3]), .ID_EX_Flush(ctlC[2]), .EX_MEM_Flush(ctlC[1]),
    .MEM_WB_Flush(ctlC[0]), .PCSrc(pcSrcC),
    .StallCount(stallC), .FlushCount(flushC)
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Waits for the next rising edge, then applies one cycle's inputs and
  // lets the combinational outputs settle well before the following edge.
  task automatic applyStimulus(
    input logic       rstN,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       usesRt,
    input logic       exMemRead,
    input logic [4:0] exDest,
    input logic       branch,
    input logic       zero,
    input logic       notZero,
    input logic [1:0] jump,
    input logic       memRead,
    input logic       memWrite
  );
    @(posedge Clk);
    #1;
    Rst_n        = rstN;
    ID_Rs        = rs;
    ID_Rt        = rt;
    ID_UsesRt    = usesRt;
    EX_MemRead   = exMemRead;
    EX_DestReg   = exDest;
    MEM_Branch   = branch;
    MEM_Zero     = zero;
    MEM_NotZero  = notZero;
    MEM_Jump     = jump;
    MEM_MemRead  = memRead;
    MEM_MemWrite = memWrite;
    #1;
  endtask

  // Idle cycle with reset released and no hazard inputs.
  task automatic idleCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  initial begin
    Rst_n        = 1'b0;
    ID_Rs        = 5'd0;
    ID_Rt        = 5'd0;
    ID_UsesRt    = 1'b0;
    EX_MemRead   = 1'b0;
    EX_DestReg   = 5'd0;
    MEM_Branch   = 1'b0;
    MEM_Zero     = 1'b0;
    MEM_NotZero  = 1'b0;
    MEM_Jump     = 2'b00;
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;

    // Reset with every hazard active: outputs must stay at normal values.
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rst_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("rst_pcSrcA", 32'(pcSrcA), 32'd0);
    checkOutput("rst_ctlB", 32'(ctlB), 32'(CTL_NORMAL));
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rst_stallA", 32'(stallA), 32'd0);
    checkOutput("rst_flushA", 32'(flushA), 32'd0);
    checkOutput("rst_stallB", 32'(stallB), 32'd0);

    idleCycle();
    checkOutput("idle_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("idle_pcSrcA", 32'(pcSrcA), 32'd0);

    // Load-use on Rs: lw $t0 in EX, ID reads $t0.
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("lu_ctlA", 32'(ctlA), 32'(CTL_LOADUSE));
    checkOutput("lu_stallA_before", 32'(stallA), 32'd0);
    idleCycle();
    checkOutput("lu_release_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("lu_stallA_after", 32'(stallA), 32'd1);
    checkOutput("lu_stallC_after", 32'(stallC), 32'd1);

    // Register 0 never hazards; Rt only hazards when used.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("lu_reg0_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    applyStimulus(1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("lu_rtUnused_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    applyStimulus(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("lu_rtUsed_ctlA", 32'(ctlA), 32'(CTL_LOADUSE));
    idleCycle();
    checkOutput("lu_stallA_2", 32'(stallA), 32'd2);

    // Taken beq.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("beq_ctlA", 32'(ctlA), 32'(CTL_REDIRECT));
    checkOutput("beq_pcSrcA", 32'(pcSrcA), 32'd1);
    idleCycle();
    checkOutput("beq_after_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("beq_flushA", 32'(flushA), 32'd1);

    // bne with Zero=1 is not taken; with Zero=0 it is.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("bneNT_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("bneNT_pcSrcA", 32'(pcSrcA), 32'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("bneT_ctlA", 32'(ctlA), 32'(CTL_REDIRECT));
    checkOutput("bneT_pcSrcA", 32'(pcSrcA), 32'd1);

    // Jumps: j -> 10, jr -> 11, reserved -> none; branch beats jump.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("j_ctlA", 32'(ctlA), 32'(CTL_REDIRECT));
    checkOutput("j_pcSrcA", 32'(pcSrcA), 32'd2);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("jr_pcSrcA", 32'(pcSrcA), 32'd3);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    checkOutput("jRsv_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("jRsv_pcSrcA", 32'(pcSrcA), 32'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("brJ_pcSrcA", 32'(pcSrcA), 32'd1);

    // Redirect beats load-use and the load-use is not counted as a stall.
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("redirLu_ctlA", 32'(ctlA), 32'(CTL_REDIRECT));
    idleCycle();
    checkOutput("redirLu_stallA", 32'(stallA), 32'd2);
    checkOutput("redirLu_flushA", 32'(flushA), 32'd6);

    // Memory wait on dutA (2 cycles) with redirect and load-use pending.
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("mem1_ctlA", 32'(ctlA), 32'(CTL_MEMSTALL));
    checkOutput("mem1_pcSrcA", 32'(pcSrcA), 32'd0);
    checkOutput("mem1_ctlC_noWait", 32'(ctlC), 32'(CTL_REDIRECT));
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("mem2_ctlA", 32'(ctlA), 32'(CTL_MEMSTALL));
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("mem3_release_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("mem3_stallA", 32'(stallA), 32'd4);
    checkOutput("mem3_flushA", 32'(flushA), 32'd6);

    // Back-to-back access re-detected immediately in RUN.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("b2b1_ctlA", 32'(ctlA), 32'(CTL_MEMSTALL));
    checkOutput("b2b1_ctlC", 32'(ctlC), 32'(CTL_NORMAL));
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("b2b2_ctlA", 32'(ctlA), 32'(CTL_MEMSTALL));
    idleCycle();
    checkOutput("b2b3_ctlA", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("b2b_stallA", 32'(stallA), 32'd6);

    // Saturation of the 4-bit stall counter.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    idleCycle();
    checkOutput("sat_stallA_15", 32'(stallA), 32'd15);
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idleCycle();
    checkOutput("sat_stallA_hold", 32'(stallA), 32'd15);
    checkOutput("sat_flushA", 32'(flushA), 32'd6);

    // Reset during the second WAIT cycle of dutB (3 wait cycles).
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rstB_clear_stallB", 32'(stallB), 32'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rstB_run_ctlB", 32'(ctlB), 32'(CTL_MEMSTALL));
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rstB_wait1_ctlB", 32'(ctlB), 32'(CTL_MEMSTALL));
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rstB_wait2_forced", 32'(ctlB), 32'(CTL_NORMAL));
    idleCycle();
    checkOutput("rstB_after_ctlB", 32'(ctlB), 32'(CTL_NORMAL));
    checkOutput("rstB_after_stallB", 32'(stallB), 32'd0);
    checkOutput("rstB_after_flushB", 32'(flushB), 32'd0);

    // Fresh access on dutB stalls exactly three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      checkOutput($sformatf("memB_stall%0d", i), 32'(ctlB), 32'(CTL_MEMSTALL));
    end
    idleCycle();
    checkOutput("memB_release_ctlB", 32'(ctlB), 32'(CTL_NORMAL));
    checkOutput("memB_stallB", 32'(stallB), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
